// File: rtl/sh_wdt_gen.sv
// sh_wdt_gen: key-protected watchdog/interval timer with overflow pulse and reset-request generator
module sh_wdt_gen #(
  parameter int          CNT_W     = 8,
  parameter int          PRE_W     = 14,
  parameter logic [31:0] DIV_LOG2  = 32'hDCA9_8761,
  parameter int          OVF_PULSE = 128,
  parameter int          RST_LEN   = 512
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [1:0]  ADDR,
  input  logic [31:0] DI,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] DO,
  output logic        ITI,
  output logic        WDTOVF_N,
  output logic        RST_REQ,
  output logic        RST_MANUAL
);
  localparam int OW = $clog2(OVF_PULSE + 1);
  localparam int RW = $clog2(RST_LEN + 1);
  typedef enum logic {IDLE, PULSE} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PRE_W-1:0]   pre, mask;
  logic [OW-1:0]      ovf_cnt;
  logic [RW-1:0]      rst_cnt;
  logic [3:0]         d;
  logic [2:0]         cks;
  logic [7:0]         key;
  logic [31:0]        rd_data;
  logic               ovf, wtit, tme, wovf, rste, rsts;
  logic               wr_csr, wr_cnt, wr_rclr, wr_rset, tick, ovf_ev, wdt_ev;
  logic               unused_di;
  assign unused_di = ^DI;
  assign key = DI[31:24];
  assign ITI = ovf & ~wtit;
  // WTCSR and WTCNT share address 0 and are told apart by the key byte; a TME-clearing write swallows a coincident tick
  always_comb begin
    wr_csr  = WE && ADDR == 2'd0 && key == 8'hA5;
    wr_cnt  = WE && ADDR == 2'd0 && key == 8'h5A;
    wr_rclr = WE && ADDR == 2'd2 && key == 8'hA5 && DI[7:0] == 8'h00;
    wr_rset = WE && ADDR == 2'd2 && key == 8'h5A;
    d       = DIV_LOG2[4*cks +: 4];
    mask    = PRE_W'((32'd1 << d) - 32'd1);
    tick    = CE && tme && !(wr_csr && !DI[5]) && (&(pre | ~mask));
    ovf_ev  = tick && !wr_cnt && (&cnt);
    wdt_ev  = ovf_ev && wtit;
    rd_data = ADDR == 2'd0 ? {24'd0, ovf, wtit, tme, 2'b11, cks} :
              ADDR == 2'd1 ? 32'(cnt) :
              ADDR == 2'd2 ? {24'd0, wovf, rste, rsts, 5'h1F} : 32'd0;
  end
  // register file, prescaler, counter and read port; status sets beat coincident clears
  always_ff @(posedge CLK) begin
    if (RST) begin
      {ovf, wtit, tme, cks} <= '0;
      {wovf, rste, rsts}    <= '0;
      cnt                   <= '0;
      pre                   <= '0;
      DO                    <= '0;
    end else begin
      if (wr_csr) {wtit, tme, cks} <= {DI[6:5], DI[2:0]};
      if (wr_rset) {rste, rsts} <= DI[6:5];
      ovf  <= (ovf_ev && !wtit) || (ovf && !(wr_csr && !DI[7]));
      wovf <= wdt_ev || (wovf && !wr_rclr);
      cnt  <= wr_cnt ? DI[CNT_W-1:0] : tick ? cnt + CNT_W'(1) : cnt;
      pre  <= !tme ? '0 : CE ? pre + PRE_W'(1) : pre;
      if (RE) DO <= rd_data;
    end
  end
  // pulse generator: one watchdog overflow arms both pulses, each timed by its own counter, ignored while busy
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      WDTOVF_N   <= 1'b1;
      RST_REQ    <= 1'b0;
      RST_MANUAL <= 1'b0;
      ovf_cnt    <= '0;
      rst_cnt    <= '0;
    end else if (CE) begin
      if (state == IDLE) begin
        if (wdt_ev) begin
          state      <= PULSE;
          WDTOVF_N   <= 1'b0;
          ovf_cnt    <= OW'(OVF_PULSE - 1);
          RST_REQ    <= rste;
          rst_cnt    <= RW'(RST_LEN - 1);
          RST_MANUAL <= rsts;
        end
      end else begin
        if (!WDTOVF_N) begin
          if (ovf_cnt == '0) WDTOVF_N <= 1'b1;
          else ovf_cnt <= ovf_cnt - OW'(1);
        end
        if (RST_REQ) begin
          if (rst_cnt == '0) RST_REQ <= 1'b0;
          else rst_cnt <= rst_cnt - RW'(1);
        end
        if ((WDTOVF_N || ovf_cnt == '0) && (!RST_REQ || rst_cnt == '0)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sh_wdt_gen.sv
// tb_sh_wdt_gen: directed tests for sh_wdt_gen in 8-bit and 16-bit counter builds
module tb_sh_wdt_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, ce = 1'b0, we = 1'b0, re = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] di = 32'd0;
  logic [31:0] do8, do16;
  logic        iti8, iti16, ovfn8, ovfn16, rq8, rq16, rm8, rm16;
  int          n_tests = 0, n_fail = 0;

  sh_wdt_gen #(.CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .ADDR(addr), .DI(di), .WE(we), .RE(re),
    .DO(do8), .ITI(iti8), .WDTOVF_N(ovfn8), .RST_REQ(rq8), .RST_MANUAL(rm8));
  sh_wdt_gen #(.CNT_W(16)) dut16 (
    .CLK(clk), .RST(rst), .CE(ce), .ADDR(addr), .DI(di), .WE(we), .RE(re),
    .DO(do16), .ITI(iti16), .WDTOVF_N(ovfn16), .RST_REQ(rq16), .RST_MANUAL(rm16));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] k, input logic [23:0] v);
    addr = a; di = {k, v}; we = 1'b1;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a; re = 1'b1;
    cyc(1);
    re = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (do8 !== 32'h0) begin n_fail++; $display("FAIL reset_do got %h want 00000000", do8); end
    n_tests++; if ({ovfn8, iti8, rq8, rm8} !== 4'b1000) begin n_fail++; $display("FAIL reset_outs got %b want 1000", {ovfn8, iti8, rq8, rm8}); end
    rd(2'd0);
    n_tests++; if (do8 !== 32'h18) begin n_fail++; $display("FAIL reset_wtcsr got %h want 00000018", do8); end
    rd(2'd1);
    n_tests++; if (do8 !== 32'h0) begin n_fail++; $display("FAIL reset_wtcnt got %h want 00000000", do8); end
    rd(2'd2);
    n_tests++; if (do8 !== 32'h1F) begin n_fail++; $display("FAIL reset_rstcsr got %h want 0000001f", do8); end
  endtask

  task automatic test_interval();
    logic [7:0] exp_cnt [6] = '{8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFF, 8'hFF};
    ce = 1'b1;
    wr(2'd0, 8'h5A, 24'hFD);
    wr(2'd0, 8'hA5, 24'h20);
    for (int i = 0; i < 6; i++) begin
      rd(2'd1);
      n_tests++; if (do8 !== 32'(exp_cnt[i])) begin n_fail++; $display("FAIL interval_cnt[%0d] got %h want %h", i, do8, exp_cnt[i]); end
      if (i == 4) begin n_tests++; if (iti8 !== 1'b0) begin n_fail++; $display("FAIL interval_iti_early got %b want 0", iti8); end end
      if (i == 5) begin n_tests++; if (iti8 !== 1'b1) begin n_fail++; $display("FAIL interval_iti_set got %b want 1", iti8); end end
    end
    rd(2'd1);
    n_tests++; if (do8 !== 32'h0) begin n_fail++; $display("FAIL interval_wrap got %h want 00000000", do8); end
    rd(2'd0);
    n_tests++; if (do8 !== 32'hB8) begin n_fail++; $display("FAIL interval_ovf got %h want 000000b8", do8); end
    wr(2'd0, 8'hA5, 24'h20);
    n_tests++; if (iti8 !== 1'b0) begin n_fail++; $display("FAIL interval_clear got %b want 0", iti8); end
    wr(2'd0, 8'hA5, 24'h00);
  endtask

  task automatic test_keys();
    wr(2'd0, 8'h5A, 24'h33);
    wr(2'd0, 8'hA5, 24'h03);
    wr(2'd1, 8'h5A, 24'h77);
    wr(2'd1, 8'hA5, 24'hE7);
    wr(2'd0, 8'h00, 24'hFF);
    wr(2'd2, 8'h12, 24'h60);
    wr(2'd2, 8'hA5, 24'h01);
    rd(2'd0);
    n_tests++; if (do8 !== 32'h1B) begin n_fail++; $display("FAIL key_wtcsr got %h want 0000001b", do8); end
    rd(2'd2);
    n_tests++; if (do8 !== 32'h1F) begin n_fail++; $display("FAIL key_rstcsr got %h want 0000001f", do8); end
    rd(2'd1);
    n_tests++; if (do8 !== 32'h33) begin n_fail++; $display("FAIL key_wtcnt got %h want 00000033", do8); end
    addr = 2'd0;
    cyc(2);
    n_tests++; if (do8 !== 32'h33) begin n_fail++; $display("FAIL read_hold got %h want 00000033", do8); end
    n_tests++; if ({ovfn8, iti8, rq8} !== 3'b100) begin n_fail++; $display("FAIL key_side_effect got %b want 100", {ovfn8, iti8, rq8}); end
    wr(2'd0, 8'hA5, 24'h80);
    rd(2'd0);
    n_tests++; if (do8 !== 32'h18) begin n_fail++; $display("FAIL ovf_w1_noeffect got %h want 00000018", do8); end
  endtask

  task automatic test_watchdog();
    int first = 0, lows = 0, rqs = 0, bad_rm = 0;
    do_reset();
    ce = 1'b1;
    wr(2'd2, 8'h5A, 24'h60);
    wr(2'd0, 8'hA5, 24'h60);
    wr(2'd0, 8'h5A, 24'hFF);
    for (int i = 1; i <= 700; i++) begin
      cyc(1);
      if (!ovfn8) begin lows++; if (first == 0) first = i; end
      if (rq8) begin rqs++; if (!rm8) bad_rm++; end
    end
    n_tests++; if (first !== 1) begin n_fail++; $display("FAIL wdt_start got %0d want 1", first); end
    n_tests++; if (lows !== 128) begin n_fail++; $display("FAIL wdtovf_len got %0d want 128", lows); end
    n_tests++; if (rqs !== 512) begin n_fail++; $display("FAIL rst_req_len got %0d want 512", rqs); end
    n_tests++; if (bad_rm !== 0) begin n_fail++; $display("FAIL rst_manual got %0d low cycles want 0", bad_rm); end
    rd(2'd2);
    n_tests++; if (do8 !== 32'hFF) begin n_fail++; $display("FAIL wdt_rstcsr got %h want 000000ff", do8); end
    rd(2'd0);
    n_tests++; if (do8 !== 32'h78 || iti8 !== 1'b0) begin n_fail++; $display("FAIL wdt_wtcsr got %h iti %b want 00000078 iti 0", do8, iti8); end
    wr(2'd0, 8'hA5, 24'h00);
    wr(2'd2, 8'hA5, 24'h00);
    rd(2'd2);
    n_tests++; if (do8 !== 32'h7F) begin n_fail++; $display("FAIL wovf_clear got %h want 0000007f", do8); end
  endtask

  task automatic test_rst_abort();
    wr(2'd0, 8'hA5, 24'h60);
    wr(2'd0, 8'h5A, 24'hFF);
    cyc(5);
    n_tests++; if ({rq8, ovfn8} !== 2'b10) begin n_fail++; $display("FAIL abort_pre got %b want 10", {rq8, ovfn8}); end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_tests++; if ({rq8, ovfn8, rm8} !== 3'b010) begin n_fail++; $display("FAIL abort_post got %b want 010", {rq8, ovfn8, rm8}); end
    rd(2'd0);
    n_tests++; if (do8 !== 32'h18) begin n_fail++; $display("FAIL abort_wtcsr got %h want 00000018", do8); end
  endtask

  task automatic test_write_wins();
    wr(2'd0, 8'hA5, 24'h20);
    wr(2'd0, 8'h5A, 24'hFF);
    wr(2'd0, 8'h5A, 24'h10);
    wr(2'd0, 8'hA5, 24'h00);
    rd(2'd1);
    n_tests++; if (do8 !== 32'h10) begin n_fail++; $display("FAIL write_wins_cnt got %h want 00000010", do8); end
    rd(2'd0);
    n_tests++; if (do8 !== 32'h18 || iti8 !== 1'b0) begin n_fail++; $display("FAIL write_wins_ovf got %h iti %b want 00000018 iti 0", do8, iti8); end
  endtask

  task automatic test_set_wins();
    wr(2'd0, 8'hA5, 24'h20);
    wr(2'd0, 8'h5A, 24'hFF);
    wr(2'd0, 8'hA5, 24'h20);
    rd(2'd0);
    n_tests++; if (do8 !== 32'hB8 || iti8 !== 1'b1) begin n_fail++; $display("FAIL set_wins got %h iti %b want 000000b8 iti 1", do8, iti8); end
    wr(2'd0, 8'hA5, 24'h00);
    wr(2'd0, 8'hA5, 24'h20);
    wr(2'd0, 8'h5A, 24'hFF);
    wr(2'd0, 8'hA5, 24'h00);
    rd(2'd1);
    n_tests++; if (do8 !== 32'hFF) begin n_fail++; $display("FAIL tme_clr_cnt got %h want 000000ff", do8); end
    rd(2'd0);
    n_tests++; if (do8 !== 32'h18 || iti8 !== 1'b0) begin n_fail++; $display("FAIL tme_clr_ovf got %h iti %b want 00000018 iti 0", do8, iti8); end
  endtask

  task automatic test_wide();
    do_reset();
    ce = 1'b1;
    wr(2'd0, 8'h5A, 24'h123456);
    rd(2'd1);
    n_tests++; if (do16 !== 32'h3456) begin n_fail++; $display("FAIL wide_mask16 got %h want 00003456", do16); end
    n_tests++; if (do8 !== 32'h56) begin n_fail++; $display("FAIL wide_mask8 got %h want 00000056", do8); end
    wr(2'd0, 8'hA5, 24'h27);
    wr(2'd0, 8'h5A, 24'hFFFF);
    cyc(8190);
    n_tests++; if (iti16 !== 1'b0) begin n_fail++; $display("FAIL cks7_early got %b want 0", iti16); end
    cyc(1);
    n_tests++; if (iti16 !== 1'b1) begin n_fail++; $display("FAIL cks7_ovf got %b want 1", iti16); end
    rd(2'd1);
    n_tests++; if (do16 !== 32'h0) begin n_fail++; $display("FAIL cks7_wrap got %h want 00000000", do16); end
    rd(2'd0);
    n_tests++; if (do16 !== 32'hBF) begin n_fail++; $display("FAIL cks7_wtcsr got %h want 000000bf", do16); end
  endtask

  initial begin
    test_reset();
    test_interval();
    test_keys();
    test_watchdog();
    test_rst_abort();
    test_write_wins();
    test_set_wins();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sh_wdt_gen.md
Name: sh_wdt_gen

Overview:
- Parametrised watchdog/interval timer for the SH-family peripheral set. It is the next generation of the 8-bit WTCNT/WTCSR/RSTCSR watchdog.
- Generalised in counter width, prescaler tap table and output pulse lengths.
- Adds key-protected writes, an overflow-signal pulse and an internal reset-request generator.
- Sits on the on-chip peripheral bus beside the INTC and BSC. ITI feeds the INTC (WDT priority); RST_REQ feeds the core reset controller.

Parameters:
- CNT_W, 8, counter width (8..24)
- PRE_W, 14, prescaler width in bits
- DIV_LOG2, {13,12,10,9,8,7,6,1}, packed 8x4-bit log2 divider per CKS value; CKS=7 is the MSB nibble
- OVF_PULSE, 128, WDTOVF_N low time in CE ticks
- RST_LEN, 512, RST_REQ high time in CE ticks

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- CE  in  1  peripheral clock enable; all state advances only when CE=1, except register writes
- ADDR  in  2  register select: 0=WTCSR, 1=WTCNT, 2=RSTCSR
- DI  in  32  write data; key in [31:24], payload in [CNT_W-1:0]
- WE  in  1  write strobe, one cycle
- RE  in  1  read strobe
- DO  out  32  read data, zero-extended
- ITI  out  1  interval interrupt request (level)
- WDTOVF_N  out  1  watchdog overflow pulse, active low
- RST_REQ  out  1  internal reset request
- RST_MANUAL  out  1  reset type qualifying RST_REQ: 1=manual, 0=power-on

Behaviour:
- Reset and reset values:
  - WTCSR reads 0x18: OVF=0, WTIT=0, TME=0, CKS=0, bits 4:3 read 1.
  - WTCNT=0; RSTCSR reads 0x1F: WOVF=0, RSTE=0, RSTS=0.
  - DO=0, ITI=0, WDTOVF_N=1, RST_REQ=0, RST_MANUAL=0; prescaler and pulse counters are 0.
  - RST mid-pulse aborts the pulse immediately.
- Writes (WE=1), all registers:
  - A write takes effect at the next CLK edge regardless of CE.
  - A key mismatch means the write is ignored with no side effects.
- WTCSR write (ADDR=0, key 0xA5):
  - Loads WTIT, TME and CKS from DI[6:5] and DI[2:0].
  - OVF (DI[7]) is R/W0: writing 0 clears it, writing 1 has no effect.
- WTCNT write (ADDR=0, key 0x5A): loads WTCNT from DI[CNT_W-1:0].
- ADDR=1 is read-only; writes to it are ignored.
- RSTCSR write (ADDR=2):
  - Key 0xA5 with DI[7:0]=0x00 clears WOVF.
  - Key 0x5A loads RSTE=DI[6] and RSTS=DI[5].
- Reads: DO is registered; it is valid the cycle after RE and holds otherwise. There are no read side effects.
- Prescaler:
  - Free-runs on CE while TME=1; held at 0 while TME=0.
  - tick = CE and TME and prescaler[d-1:0] all ones, where d = DIV_LOG2[CKS].
  - A CKS change takes effect on the next tick evaluation without clearing the prescaler.
- Counter: on tick, WTCNT increments. The tick at all-ones wraps WTCNT to 0 and raises an overflow event.
- Overflow event, interval mode (WTIT=0): OVF is set. ITI = OVF & ~WTIT, a level held until software clears OVF.
- Overflow event, watchdog mode (WTIT=1):
  - WOVF is set.
  - WDTOVF_N is driven low for exactly OVF_PULSE CE ticks, starting the cycle after the event.
  - If RSTE=1, RST_REQ goes high for RST_LEN CE ticks. RST_MANUAL is latched from RSTS at the event and held for the pulse.
- Pulse FSM: IDLE -> PULSE (ovf event) -> IDLE (count done).
  - A new overflow during PULSE restarts neither pulse.
  - WDTOVF_N and RST_REQ use independent counters.
- Simultaneous events:
  - WTCNT write coincident with a tick: the write wins and no overflow occurs.
  - OVF/WOVF clear coincident with set: set wins.
  - TME cleared coincident with a tick: the tick is suppressed.
- Width rules: payload bits above CNT_W are ignored on write and read back as 0.

Test Plan:
- Reset, then read ADDR 0/1/2 -> DO = 0x18, 0x00, 0x1F; WDTOVF_N=1, ITI=0.
- CE=1 constant; write WTCNT key 0x5A data 0xFD; write WTCSR key 0xA5 data 0x20 (TME, CKS=0, d=1) -> WTCNT 0xFE after 2 cycles. At 6 cycles WTCNT=0x00, OVF=1, ITI=1. Writing WTCSR 0xA5 with data 0x20 clears ITI.
- Write WTCSR with key 0x5A, or WTCNT with key 0xA5 -> registers unchanged, no side effects.
- Watchdog mode: RSTCSR key 0x5A data 0x60 (RSTE=1, RSTS=1), WTCSR 0xA5 data 0x60, WTCNT 0xFF, CE=1 -> after 2 cycles WDTOVF_N low exactly 128 cycles; RST_REQ=1 and RST_MANUAL=1 for exactly 512 cycles; RSTCSR reads 0xFF.
- Write WTCNT 0x10 in the same cycle as a tick at 0xFF -> WTCNT=0x10, no OVF. Assert RST during the RST_REQ pulse -> RST_REQ=0 next cycle.
- CNT_W=16, CKS=7 (d=13): counter from 0xFFFF overflows after 8192 CE ticks; DO upper bits read 0.
